// File: rtl/ece453_bus_arbiter.sv
// ece453_bus_arbiter: round-robin arbiter sharing the register-bank Avalon-MM slave; define ECE453_ARB_LOCK_EN to let an owner keep the bus via req_lock
module ece453_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [5*NUM_REQ-1:0]  req_address,
  input  logic [32*NUM_REQ-1:0] req_writedata,
  input  logic [4*NUM_REQ-1:0]  req_byteenable,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rd_data,
  output logic [4:0]            slave_address,
  output logic                  slave_read,
  output logic                  slave_write,
  output logic [31:0]           slave_writedata,
  output logic [3:0]            slave_byteenable,
  input  logic [31:0]           slave_readdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] owner, owner_nx, rr_ptr, winner, ptr_inc;
  logic [IDX_W:0] pos;
  logic [NUM_REQ-1:0] rot;
  logic lock_r, hold, issue, acking;
  // rotate req so bit k is requester rr_ptr+k; walking down leaves the nearest one as winner
  always_comb begin
    rot = NUM_REQ'({req, req} >> rr_ptr);
    winner = rr_ptr;
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rot[k]) winner = IDX_W'(pos >= (IDX_W+1)'(NUM_REQ) ? pos - (IDX_W+1)'(NUM_REQ) : pos);
    end
  end
`ifdef ECE453_ARB_LOCK_EN
  assign hold = lock_r & req[owner];
  // lock is sampled with the command and lapses as soon as the owner stops requesting
  always_ff @(posedge clk)
    if (reset) lock_r <= 1'b0;
    else if (state == ISSUE) lock_r <= req_lock[owner];
    else if (state == IDLE && !hold) lock_r <= 1'b0;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_r = 1'b0;
  assign hold = 1'b0;
`endif
  // next state and owner; a held lock re-grants the current owner ahead of the scan
  always_comb begin
    state_nx = state == IDLE ? (|req ? ISSUE : IDLE) : (state == ISSUE ? ACK : IDLE);
    owner_nx = (state == IDLE && |req && !hold) ? winner : owner;
  end
  assign ptr_inc = owner == IDX_W'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  // state, owner, round-robin pointer and read-data capture
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      if (state == ISSUE) rd_data <= slave_readdata;
      if (state == ACK && !lock_r) rr_ptr <= ptr_inc;
    end
  assign issue = state == ISSUE && !reset;
  assign acking = state == ACK && !reset;
  assign gnt = issue ? NUM_REQ'(1) << owner : '0;
  assign ack = acking ? NUM_REQ'(1) << owner : '0;
  assign slave_write = issue & req_write[owner];
  assign slave_read = issue & req_read[owner] & ~req_write[owner];
  assign slave_address = issue ? req_address[5*owner +: 5] : '0;
  assign slave_writedata = issue ? req_writedata[32*owner +: 32] : '0;
  assign slave_byteenable = issue ? req_byteenable[4*owner +: 4] : '0;
endmodule

// File: tb/tb_ece453_bus_arbiter.sv
// tb_ece453_bus_arbiter: directed stimulus against a transaction-level model plus hand-computed expectations
module tb_ece453_bus_arbiter;
  localparam int N = 4;
`ifdef ECE453_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, req_read, req_write, req_lock, gnt, ack;
  logic [5*N-1:0] req_address;
  logic [32*N-1:0] req_writedata;
  logic [4*N-1:0] req_byteenable;
  logic [31:0] rd_data, slave_writedata, slave_readdata;
  logic [4:0] slave_address;
  logic slave_read, slave_write;
  logic [3:0] slave_byteenable;
  logic [31:0] mem [32];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_ph, m_owner, m_ptr;
  bit m_lock;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  ece453_bus_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req(req), .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_lock(req_lock), .gnt(gnt), .ack(ack), .rd_data(rd_data),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
    .slave_readdata(slave_readdata)
  );

  assign slave_readdata = slave_address == 5'd0 ? 32'hECE45318 : mem[slave_address];

  function logic [31:0] bank_rd(input logic [4:0] a);
    return a == 5'd0 ? 32'hECE45318 : mem[a];
  endfunction

  // register bank stand-in: word 0 is the read-only device ID
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset)
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A50000 | 32'(i);
    else if (slave_write && slave_address != 5'd0)
      for (int b = 0; b < 4; b++)
        if (slave_byteenable[b]) mem[slave_address][8*b +: 8] <= slave_writedata[8*b +: 8];
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // transaction model: grant slot, issue slot, ack slot
  always @(posedge clk)
    if (reset) begin
      m_ph <= 0; m_owner <= 0; m_ptr <= 0; m_lock <= 1'b0; m_rd <= '0;
    end else if (m_ph == 0) begin
      if (|req) begin
        m_ph <= 1;
        if (!(LOCK && m_lock && req[m_owner])) begin
          m_owner <= pick(req, m_ptr);
          m_lock <= 1'b0;
        end
      end else m_lock <= 1'b0;
    end else if (m_ph == 1) begin
      m_rd <= bank_rd(req_address[5*m_owner +: 5]);
      m_lock <= LOCK && req_lock[m_owner];
      m_ph <= 2;
    end else begin
      if (!m_lock) m_ptr <= (m_owner + 1) % N;
      m_ph <= 0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function bit iss();
    return !reset && m_ph == 1;
  endfunction

  function bit ackc();
    return !reset && m_ph == 2;
  endfunction

  always @(negedge clk) begin
    chk("gnt", 32'(gnt), iss() ? 32'(1) << m_owner : 32'd0);
    chk("ack", 32'(ack), ackc() ? 32'(1) << m_owner : 32'd0);
    chk("rd_data", rd_data, m_rd);
    chk("slave_address", 32'(slave_address), iss() ? 32'(req_address[5*m_owner +: 5]) : 32'd0);
    chk("slave_writedata", slave_writedata, iss() ? req_writedata[32*m_owner +: 32] : 32'd0);
    chk("slave_byteenable", 32'(slave_byteenable), iss() ? 32'(req_byteenable[4*m_owner +: 4]) : 32'd0);
    chk("slave_write", 32'(slave_write), 32'(iss() && req_write[m_owner]));
    chk("slave_read", 32'(slave_read), 32'(iss() && req_read[m_owner] && !req_write[m_owner]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic r, input logic w, input logic [4:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
    req_read[i] = r;
    req_write[i] = w;
    req_address[5*i +: 5] = ad;
    req_writedata[32*i +: 32] = d;
    req_byteenable[4*i +: 4] = be;
    req[i] = 1'b1;
  endtask

  task automatic wait_any(output logic [N-1:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == '0 && n < 12);
    a = ack;
    chk("ack_seen", 32'(|ack), 32'd1);
  endtask

  initial begin
    logic [N-1:0] a;
    int t0, tp;
    int ord[5];
    int lk[4];
    ord = '{0, 1, 2, 3, 0};
    if (LOCK) lk = '{3, 3, 3, 0};
    else lk = '{3, 0, 3, 0};
    reset = 1'b1;
    req = '0; req_read = '0; req_write = '0; req_lock = '0;
    req_address = '0; req_writedata = '0; req_byteenable = '0;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 1'b0, 5'(i + 1), 32'd0, 4'hF);
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_slave_read", 32'(slave_read), 32'd0);
    chk("rst_slave_address", 32'(slave_address), 32'd0);
    tick();
    reset = 1'b0;
    t0 = cyc;
    tp = cyc;
    for (int n = 0; n < 5; n++) begin
      wait_any(a);
      chk("rr_order", 32'(a), 32'(1) << ord[n]);
      chk("rr_spacing", 32'(cyc - (n == 0 ? t0 : tp)), n == 0 ? 32'd2 : 32'd3);
      tp = cyc;
    end
    tick();
    req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_cmd(0, 1'b0, 1'b1, 5'd1, 32'h3, 4'hF);
    @(negedge clk);
    chk("wr_c0_gnt", 32'(gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("wr_gnt", 32'(gnt), 32'd1);
    chk("wr_slave_write", 32'(slave_write), 32'd1);
    chk("wr_slave_address", 32'(slave_address), 32'd1);
    chk("wr_slave_writedata", slave_writedata, 32'h3);
    tick();
    @(negedge clk);
    chk("wr_ack", 32'(ack), 32'd1);
    chk("wr_ack_gnt", 32'(gnt), 32'd0);
    tick();
    req[0] = 1'b0;
    set_cmd(3, 1'b1, 1'b0, 5'd1, 32'd0, 4'hF);
    wait_any(a);
    chk("rb1_ack", 32'(a), 32'd8);
    chk("rb1_data", rd_data, 32'h3);
    tick();
    req[3] = 1'b0;
    set_cmd(2, 1'b1, 1'b0, 5'd0, 32'd0, 4'hF);
    wait_any(a);
    chk("id_ack", 32'(a), 32'd4);
    chk("id_data", rd_data, 32'hECE45318);
    tick();
    req[2] = 1'b0;
    set_cmd(1, 1'b1, 1'b1, 5'd5, 32'h12345678, 4'b0011);
    tick();
    @(negedge clk);
    chk("rw_gnt", 32'(gnt), 32'd2);
    chk("rw_slave_write", 32'(slave_write), 32'd1);
    chk("rw_slave_read", 32'(slave_read), 32'd0);
    chk("rw_byteenable", 32'(slave_byteenable), 32'd3);
    wait_any(a);
    chk("rw_ack", 32'(a), 32'd2);
    tick();
    req[1] = 1'b0;
    set_cmd(0, 1'b1, 1'b0, 5'd5, 32'd0, 4'hF);
    wait_any(a);
    chk("be_ack", 32'(a), 32'd1);
    chk("be_data", rd_data, 32'hA5A55678);
    tick();
    req[0] = 1'b0;
    set_cmd(0, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 4'hF);
    tick();
    reset = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    chk("rst_issue_write", 32'(slave_write), 32'd0);
    chk("rst_issue_gnt", 32'(gnt), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after_ack", 32'(ack), 32'd0);
    chk("rst_after_gnt", 32'(gnt), 32'd0);
    chk("rst_after_rd", rd_data, 32'd0);
    chk("rst_after_write", 32'(slave_write), 32'd0);
    tick();
    set_cmd(3, 1'b1, 1'b0, 5'd2, 32'd0, 4'hF);
    set_cmd(0, 1'b1, 1'b0, 5'd7, 32'd0, 4'hF);
    wait_any(a);
    chk("ptr_reset_ack", 32'(a), 32'd1);
    chk("rst_no_write", rd_data, 32'hA5A50007);
    tick();
    req[0] = 1'b0;
    wait_any(a);
    chk("ptr_reset_next", 32'(a), 32'd8);
    tick();
    req[3] = 1'b0;
    set_cmd(3, 1'b0, 1'b1, 5'd9, 32'hAA, 4'hF);
    req_lock[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_any(a);
      chk("lock_order", 32'(a), 32'(1) << lk[n]);
      tick();
      if (n == 0) set_cmd(0, 1'b1, 1'b0, 5'd9, 32'd0, 4'hF);
      if (n == 1) req_lock[3] = 1'b0;
    end
    req = '0;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ece453_bus_arbiter.md
# ece453_bus_arbiter

Round-robin arbiter that shares the single Avalon-MM slave port of the ece453 register bank (5-bit word address, 32-bit data) between NUM_REQ local requesters, for example the HPS bridge, an LED sequencer and a debug UART bridge. It sits between the requesters and the register bank's slave_* inputs. It serialises requests into one-cycle bus transactions and returns read data with a per-requester acknowledge.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ), width of the owner index.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request, one bit per requester; held high until that requester's ack.
- req_read  in  NUM_REQ  read command, per requester.
- req_write  in  NUM_REQ  write command, per requester.
- req_address  in  5*NUM_REQ  word address; requester i uses bits [5i+4:5i].
- req_writedata  in  32*NUM_REQ  write data; requester i uses bits [32i+31:32i].
- req_byteenable  in  4*NUM_REQ  byte enables; requester i uses bits [4i+3:4i].
- req_lock  in  NUM_REQ  keep ownership for the next transaction (only used with ECE453_ARB_LOCK_EN).
- gnt  out  NUM_REQ  one-hot; high during the ISSUE cycle for the owner.
- ack  out  NUM_REQ  one-hot, one-cycle pulse; the transaction is complete.
- rd_data  out  32  captured read data; valid while ack is high.
- slave_address  out  5  to the register bank.
- slave_read  out  1  to the register bank.
- slave_write  out  1  to the register bank.
- slave_writedata  out  32  to the register bank.
- slave_byteenable  out  4  to the register bank.
- slave_readdata  in  32  combinational read data from the register bank.

## Operation
- The FSM has three states: IDLE, ISSUE and ACK.
- IDLE: if any req bit is high, select a winner, register it into owner, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: gnt[owner]=1. The slave_* outputs are driven combinationally from the owner's command fields. At the clock edge, rd_data <= slave_readdata, then go to ACK.
- ACK: ack[owner]=1 and rd_data is held. Update the pointer: rr_ptr <= (owner+1) mod NUM_REQ. Go to IDLE.
- Winner selection: the first requester with req high, scanning rr_ptr, rr_ptr+1, … with wrap-around modulo NUM_REQ.
- Read and write both high: treat as a write. slave_read=0, slave_write=1. rd_data captures slave_readdata anyway.
- Neither read nor write high: the transaction is still granted and acked, with slave_read=slave_write=0. rd_data equals slave_readdata for the presented address.
- Outside ISSUE: slave_read=0, slave_write=0, and slave_address, slave_writedata and slave_byteenable are all 0.
- The requester must hold its req and command fields stable from req rise through its ack cycle, and must deassert req (or present a new command) in the cycle after ack.
- A req bit dropping before its grant is legal; that requester is simply not selected.
- After reset, rr_ptr=0, so requester 0 has highest priority.

## Timing
- Reset values: gnt=0, ack=0, rd_data=0, all slave_* outputs=0, state=IDLE, rr_ptr=0, owner=0, lock_r=0.
- Reset is sampled at the clock edge. If reset is asserted in ISSUE or ACK, the in-flight transaction is abandoned: no ack, no further write.
- Latency: req high in cycle 0 (IDLE) gives ISSUE in cycle 1 and ack in cycle 2.
- Throughput: at most one transaction per 3 cycles.
- The write takes effect at the end of the ISSUE cycle, which is the register bank's clock edge.
- rd_data reflects register contents as of the ISSUE cycle.
- Simultaneous requests in IDLE are resolved in a single cycle by the round-robin scan.

## Configuration
- ECE453_ARB_LOCK_EN defined:
  - lock_r <= req_lock[owner] is captured in ISSUE.
  - In IDLE, if lock_r=1 and req[owner]=1, the owner is re-granted regardless of rr_ptr, and rr_ptr is not advanced in that ACK.
  - If lock_r=1 but req[owner]=0, lock_r clears and normal round-robin applies.
- ECE453_ARB_LOCK_EN undefined:
  - req_lock is ignored and lock_r is tied to 0.
  - Pure round-robin.

## Test plan
- Reset, then req=4'b0001, write, address 5'd1, data 32'h3 -> gnt[0] in cycle 1 with slave_write=1 and slave_address=1 -> ack[0] in cycle 2.
- All four req held high continuously from reset -> grant order 0,1,2,3,0 with one ack every 3 cycles.
- Requester 2 reads address 0 (device ID) -> rd_data=32'hECE45318 while ack[2]=1.
- Requester 1 asserts read and write together -> slave_write=1 and slave_read=0 during ISSUE.
- Reset asserted during ISSUE of a write -> no ack; all outputs 0 the next cycle; rr_ptr=0.
- With ECE453_ARB_LOCK_EN, requester 3 holds req and req_lock high while requester 0 also requests -> requester 3 wins back-to-back until it drops req_lock, then requester 0 is granted next.
